// File: rtl/cricket_scoreboard_display.sv
`default_nettype none
// ============================================================================
//  Module      : cricket_scoreboard_display
//  Description : Scoreboard driver for a 4-digit multiplexed common-anode
//                7-segment display. Runs are converted to BCD by a sequential
//                double-dabble engine. Digit 3 shows wickets and digits 2..0
//                show runs with leading-zero blanking. In game-over mode the
//                display alternates between a winner banner and the score.
//  Ports       : clk          system clock
//                reset        synchronous, active-high reset
//                runs[7:0]    current innings runs
//                wickets[3:0] current wickets (>=10 shows 'A')
//                inning_over  lights the digit-3 decimal point
//                game_over    enables banner/score alternation
//                winner       0 = team1, 1 = team2
//                an[3:0]      anode enables, active-low, one-hot-low
//                seg[6:0]     {g,f,e,d,c,b,a}, active-low
//                dp           decimal point, active-low
//                busy         BCD conversion in progress
//                bcd[11:0]    displayed runs {hund,tens,ones}
//  Revision    : 1.0 - initial release
// ============================================================================
module cricket_scoreboard_display #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  runs,
   input  logic [3:0]  wickets,
   input  logic        inning_over,
   input  logic        game_over,
   input  logic        winner,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        busy,
   output logic [11:0] bcd
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [REF_W-1:0] c_REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [FRM_W-1:0] c_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_SHIFT = 2'd1;
   localparam logic [1:0] c_S_DONE  = 2'd2;

   // Step 0 of SHIFT loads the latched binary; steps 1..8 are the shifts.
   localparam logic [3:0] c_LAST_STEP = 4'd8;

   localparam logic [6:0] c_G_A     = 7'b0001000;
   localparam logic [6:0] c_G_DASH  = 7'b0111111;
   localparam logic [6:0] c_G_BLANK = 7'b1111111;

   function automatic logic [6:0] f_glyph(input logic [3:0] i_val);
      case (i_val)
         4'd0:    f_glyph = 7'b1000000;
         4'd1:    f_glyph = 7'b1111001;
         4'd2:    f_glyph = 7'b0100100;
         4'd3:    f_glyph = 7'b0110000;
         4'd4:    f_glyph = 7'b0011001;
         4'd5:    f_glyph = 7'b0010010;
         4'd6:    f_glyph = 7'b0000010;
         4'd7:    f_glyph = 7'b1111000;
         4'd8:    f_glyph = 7'b0000000;
         4'd9:    f_glyph = 7'b0010000;
         default: f_glyph = c_G_A;      // wickets 10..15 read as all out
      endcase
   endfunction

   // ------------------------------------------------------------------
   // BCD converter
   // ------------------------------------------------------------------
   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [3:0]  r_cnt;
   logic [7:0]  r_snap_runs;
   logic [3:0]  r_snap_wkt;
   logic [19:0] r_scr;          // {hund,tens,ones,binary}
   logic [19:0] w_adj;
   logic [19:0] w_shifted;
   logic [11:0] r_bcd;
   logic [3:0]  r_wkt;
   logic        r_busy;
   logic        w_diff;
   logic        w_start;
   logic        w_shift;
   logic        w_done;

   assign w_diff = ({runs, wickets} != {r_snap_runs, r_snap_wkt});

   for (genvar g = 0; g < 3; g++) begin : g_adj
      assign w_adj[8+4*g +: 4] = (r_scr[8+4*g +: 4] >= 4'd5) ?
                                 (r_scr[8+4*g +: 4] + 4'd3) : r_scr[8+4*g +: 4];
   end
   assign w_adj[7:0] = r_scr[7:0];
   assign w_shifted  = {w_adj[18:0], 1'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE:  if (w_diff) w_state_next = c_S_SHIFT;
         c_S_SHIFT: if (r_cnt == c_LAST_STEP) w_state_next = c_S_DONE;
         c_S_DONE:  w_state_next = c_S_IDLE;
         default:   w_state_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_start = 1'b0;
      w_shift = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         c_S_IDLE:  w_start = w_diff;
         c_S_SHIFT: w_shift = 1'b1;
         c_S_DONE:  w_done  = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap_runs <= 8'd0;
         r_snap_wkt  <= 4'd0;
         r_scr       <= 20'd0;
         r_cnt       <= 4'd0;
         r_bcd       <= 12'd0;
         r_wkt       <= 4'd0;
         r_busy      <= 1'b0;
      end else begin
         if (w_start) begin
            r_snap_runs <= runs;
            r_snap_wkt  <= wickets;
            r_scr       <= 20'd0;
            r_cnt       <= 4'd0;
         end
         if (w_shift) begin
            r_busy <= 1'b1;
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'd0) begin
               r_scr <= {12'd0, r_snap_runs};
            end else begin
               r_scr <= w_shifted;
            end
         end
         // Display registers change only here, so no partial result is shown.
         if (w_done) begin
            r_bcd  <= r_scr[19:8];
            r_wkt  <= r_snap_wkt;
            r_busy <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Display scan and game-over alternation
   // ------------------------------------------------------------------
   logic [REF_W-1:0] r_ref;
   logic [1:0]       r_idx;
   logic [FRM_W-1:0] r_frm;
   logic             r_phase;     // 0 = banner, 1 = score
   logic             r_go_d;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             w_ref_wrap;
   logic             w_frame_tick;
   logic [6:0]       w_seg;
   logic             w_dp;
   logic [3:0]       w_hund;
   logic [3:0]       w_tens;
   logic [3:0]       w_ones;

   assign w_ref_wrap   = (r_ref == c_REF_LAST);
   assign w_frame_tick = w_ref_wrap && (r_idx == 2'd3);
   assign w_hund       = r_bcd[11:8];
   assign w_tens       = r_bcd[7:4];
   assign w_ones       = r_bcd[3:0];

   always_comb begin
      w_seg = c_G_BLANK;
      if (game_over && !r_phase) begin
         case (r_idx)
            2'd3:    w_seg = c_G_DASH;
            2'd0:    w_seg = f_glyph(winner ? 4'd2 : 4'd1);
            default: w_seg = c_G_BLANK;
         endcase
      end else begin
         case (r_idx)
            2'd3:    w_seg = f_glyph(r_wkt);
            2'd2:    w_seg = (w_hund == 4'd0) ? c_G_BLANK : f_glyph(w_hund);
            2'd1:    w_seg = ((w_hund == 4'd0) && (w_tens == 4'd0)) ?
                             c_G_BLANK : f_glyph(w_tens);
            default: w_seg = f_glyph(w_ones);
         endcase
      end
      w_dp = game_over ? 1'b1 : !((r_idx == 2'd3) && inning_over);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ref   <= '0;
         r_idx   <= 2'd0;
         r_frm   <= '0;
         r_phase <= 1'b0;
         r_go_d  <= 1'b0;
         r_an    <= 4'b1111;
         r_seg   <= c_G_BLANK;
         r_dp    <= 1'b1;
      end else begin
         // an/seg/dp come from the same index so they always agree.
         r_an   <= ~(4'b0001 << r_idx);
         r_seg  <= w_seg;
         r_dp   <= w_dp;
         r_go_d <= game_over;

         if (w_ref_wrap) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_ref <= r_ref + REF_W'(1);
         end

         // A new game-over always opens with the banner.
         if (game_over && !r_go_d) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
         end else if (game_over && w_frame_tick) begin
            if (r_frm == c_FRM_LAST) begin
               r_frm   <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_frm <= r_frm + FRM_W'(1);
            end
         end
      end
   end

   assign an   = r_an;
   assign seg  = r_seg;
   assign dp   = r_dp;
   assign busy = r_busy;
   assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_cricket_scoreboard_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cricket_scoreboard_display
//  Description : Self-checking bench for cricket_scoreboard_display using a
//                conversion scoreboard and a reference scan/glyph model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cricket_scoreboard_display;

   localparam int RD = 2;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  runs = 8'd0;
   logic [3:0]  wickets = 4'd0;
   logic        inning_over = 1'b0;
   logic        game_over = 1'b0;
   logic        winner = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        busy;
   logic [11:0] bcd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [11:0] bcd;
      logic [3:0]  wkt;
      int          start;
      int          due;
   } item_t;
   item_t sb[$];

   logic [11:0] m_bcd = 12'd0;
   logic [3:0]  m_wkt = 4'd0;
   logic        m_io  = 1'b0;
   logic        m_go  = 1'b0;
   logic        m_win = 1'b0;
   int          m_r   = 0;

   cricket_scoreboard_display #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .runs(runs), .wickets(wickets),
      .inning_over(inning_over), .game_over(game_over), .winner(winner),
      .an(an), .seg(seg), .dp(dp), .busy(busy), .bcd(bcd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int idx_of(input int c);
      return ((c - 1) / RD) % 4;
   endfunction

   function automatic bit banner_on(input int c);
      int w;
      if (!m_go) return 1'b0;
      w = (c > m_r) ? ((c - 1) / (4 * RD) - m_r / (4 * RD)) : 0;
      return ((w / BF) % 2) == 0;
   endfunction

   function automatic logic [3:0] exp_an(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << idx_of(c));
   endfunction

   function automatic logic [6:0] exp_seg(input int c);
      int i;
      int h, t, o;
      i = idx_of(c);
      h = int'(m_bcd[11:8]);
      t = int'(m_bcd[7:4]);
      o = int'(m_bcd[3:0]);
      if (banner_on(c)) begin
         if (i == 3) return glyph(11);
         if (i == 0) return glyph(m_win ? 2 : 1);
         return glyph(12);
      end
      case (i)
         3: return glyph((m_wkt >= 4'd10) ? 10 : int'(m_wkt));
         2: return (h == 0) ? glyph(12) : glyph(h);
         1: return (h == 0 && t == 0) ? glyph(12) : glyph(t);
         default: return glyph(o);
      endcase
   endfunction

   function automatic logic exp_dp(input int c);
      if (m_go) return 1'b1;
      return (idx_of(c) == 3 && m_io) ? 1'b0 : 1'b1;
   endfunction

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got=%b want=1111", an); end
      n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got=%b want=1111111", seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b want=1", dp); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got=%h want=000", bcd); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL release_an got=%b want=1110", an); end
      n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL release_seg got=%b want=1000000", seg); end
   endtask

   // Steps the scoreboard: items complete at their due sample.
   task automatic test_conversion(input string name, input int nsamp,
                                  input int chg_at, input logic [7:0] chg_runs);
      logic exp_busy;
      for (int s = 0; s < nsamp; s++) begin
         @(negedge clk);
         if (sb.size() > 0 && sb[0].due == s) begin
            m_bcd = sb[0].bcd;
            m_wkt = sb[0].wkt;
            void'(sb.pop_front());
         end
         exp_busy = 1'b0;
         foreach (sb[j]) if (s > sb[j].start && s < sb[j].due) exp_busy = 1'b1;
         n_checks++;
         if (busy !== exp_busy) begin
            n_fail++; $display("FAIL %s_busy s=%0d got=%b want=%b", name, s, busy, exp_busy);
         end
         n_checks++;
         if (bcd !== m_bcd) begin
            n_fail++; $display("FAIL %s_bcd s=%0d got=%h want=%h", name, s, bcd, m_bcd);
         end
         if (s == chg_at) runs = chg_runs;
      end
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL %s_pending got=%0d items want=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_scan(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         n_checks++;
         if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     name, cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
         end
      end
   endtask

   task automatic test_convert_255();
      runs = 8'd255; wickets = 4'd3;
      sb.push_back('{12'h255, 4'd3, 0, 10});
      test_conversion("conv255", 11, -1, 8'd0);
      test_scan("scan255", 16);
   endtask

   task automatic test_blanking();
      runs = 8'd7;
      sb.push_back('{12'h007, 4'd3, 0, 10});
      test_conversion("conv7", 11, -1, 8'd0);
      test_scan("blank7", 16);
      runs = 8'd40; wickets = 4'd10;
      sb.push_back('{12'h040, 4'd10, 0, 10});
      test_conversion("conv40", 11, -1, 8'd0);
      test_scan("blank40_allout", 16);
   endtask

   task automatic test_back_to_back();
      runs = 8'd100;
      sb.push_back('{12'h100, 4'd10, 0, 10});
      sb.push_back('{12'h101, 4'd10, 11, 21});
      test_conversion("b2b", 22, 3, 8'd101);
      test_scan("scan101", 8);
   endtask

   task automatic test_inning_dp();
      inning_over = 1'b1; m_io = 1'b1;
      test_scan("inning_dp", 16);
      inning_over = 1'b0; m_io = 1'b0;
      test_scan("inning_off", 8);
   endtask

   task automatic test_game_over();
      winner = 1'b1; m_win = 1'b1;
      if (((cyc + 1) % (4 * RD)) == 0) @(negedge clk);
      game_over = 1'b1; m_go = 1'b1; m_r = cyc + 1;
      test_scan("game_over", 48);
      game_over = 1'b0; m_go = 1'b0;
      test_scan("game_over_off", 16);
   endtask

   task automatic test_reset_mid();
      runs = 8'd200; wickets = 4'd5;
      for (int s = 0; s < 4; s++) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%b want=1", busy); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
      n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL mid_reset_bcd got=%h want=000", bcd); end
      n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_an got=%b want=1111", an); end
      runs = 8'd0; wickets = 4'd0;
      m_bcd = 12'd0; m_wkt = 4'd0;
      @(negedge clk);
      reset = 1'b0;
      test_scan("after_mid_reset", 8);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL after_mid_busy got=%b want=0", busy); end
   endtask

   initial begin
      test_reset();
      test_convert_255();
      test_blanking();
      test_back_to_back();
      test_inning_dp();
      test_game_over();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
